// File: rtl/mc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : mc_fetch_unit
// Purpose  : Fetch/state datapath slice of a multi-cycle processor. Holds the
//            control-state register, PC, IR, MDR and ALUOut registers. It also
//            drives the memory address mux, counts instruction fetches and
//            flags illegal control states with a sticky bit.
// Ports    : clk, rst                  - clock, async active-high reset
//            NS                        - next control state (loaded every edge)
//            PCWr, PCWrCond, Zero      - PC write enables / branch qualifier
//            PCSrc                     - next-PC select
//            IorD                      - memory address select (0=PC,1=ALUOut)
//            IRWr                      - IR load enable (also counts fetches)
//            ALU_Result, Mem_Data      - same-cycle ALU output / memory data
//            S, OP_Code, Funct         - state and decode fields to control
//            PC, Mem_Addr, IR, MDR,
//            ALUOut                    - datapath registers and address
//            InstrCount, StateErr      - fetch counter, sticky illegal-state
// Revision : 1.0 - initial release
// ============================================================================
module mc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [3:0]  MAX_STATE   = 4'd9,
    // Reset value of the fetch counter. Leave at zero in normal use; a
    // non-zero value only exists so the wrap-around can be exercised.
    parameter logic [31:0] COUNT_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  NS,
    input  logic        PCWr,
    input  logic        PCWrCond,
    input  logic [1:0]  PCSrc,
    input  logic        IorD,
    input  logic        IRWr,
    input  logic        Zero,
    input  logic [31:0] ALU_Result,
    input  logic [31:0] Mem_Data,
    output logic [3:0]  S,
    output logic [5:0]  OP_Code,
    output logic [5:0]  Funct,
    output logic [31:0] PC,
    output logic [31:0] Mem_Addr,
    output logic [31:0] IR,
    output logic [31:0] MDR,
    output logic [31:0] ALUOut,
    output logic [31:0] InstrCount,
    output logic        StateErr
);

    logic [3:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_mdr;
    logic [31:0] r_alu_out;
    logic [31:0] r_instr_count;
    logic        r_state_err;

    logic        w_pc_en;
    logic [31:0] w_pc_next;

    // Next-PC selection. PCSrc=11 selects the current PC so an enabled
    // write with that select behaves as a hold.
    always_comb begin
        w_pc_en = PCWr | (PCWrCond & Zero);
        case (PCSrc)
            2'b00:   w_pc_next = ALU_Result;
            2'b01:   w_pc_next = r_alu_out;
            2'b10:   w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
            default: w_pc_next = r_pc;
        endcase
    end

    // Control state: loaded unconditionally, illegal encodings included.
    // The error flag is the only reaction to an out-of-range state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= 4'd0;
            r_state_err <= 1'b0;
        end else begin
            r_state <= NS;
            if (NS > MAX_STATE) begin
                r_state_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (w_pc_en) begin
            r_pc <= w_pc_next;
        end
    end

    // IR and the fetch counter share IRWr. IR captures Mem_Data that was
    // addressed by the pre-update PC when a PC write occurs in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir          <= 32'h0000_0000;
            r_instr_count <= COUNT_RESET;
        end else if (IRWr) begin
            r_ir          <= Mem_Data;
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mdr     <= 32'h0000_0000;
            r_alu_out <= 32'h0000_0000;
        end else begin
            r_mdr     <= Mem_Data;
            r_alu_out <= ALU_Result;
        end
    end

    assign S          = r_state;
    assign PC         = r_pc;
    assign IR         = r_ir;
    assign MDR        = r_mdr;
    assign ALUOut     = r_alu_out;
    assign InstrCount = r_instr_count;
    assign StateErr   = r_state_err;
    assign OP_Code    = r_ir[31:26];
    assign Funct      = r_ir[5:0];
    assign Mem_Addr   = IorD ? r_alu_out : r_pc;

endmodule
`default_nettype wire

// File: tb/tb_mc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_fetch_unit
// Purpose  : Self-checking bench for mc_fetch_unit: directed vector table,
//            hand-written multi-cycle sequences and randomized stimulus
//            against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  NS;
    logic        PCWr, PCWrCond, IorD, IRWr, Zero;
    logic [1:0]  PCSrc;
    logic [31:0] ALU_Result, Mem_Data;

    logic [3:0]  S;
    logic [5:0]  OP_Code, Funct;
    logic [31:0] PC, Mem_Addr, IR, MDR, ALUOut, InstrCount;
    logic        StateErr;

    logic [3:0]  w2_s;
    logic [5:0]  w2_op, w2_funct;
    logic [31:0] w2_pc, w2_addr, w2_ir, w2_mdr, w2_alu, w2_cnt;
    logic        w2_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_fetch_unit dut (
        .clk(clk), .rst(rst), .NS(NS), .PCWr(PCWr), .PCWrCond(PCWrCond),
        .PCSrc(PCSrc), .IorD(IorD), .IRWr(IRWr), .Zero(Zero),
        .ALU_Result(ALU_Result), .Mem_Data(Mem_Data),
        .S(S), .OP_Code(OP_Code), .Funct(Funct), .PC(PC), .Mem_Addr(Mem_Addr),
        .IR(IR), .MDR(MDR), .ALUOut(ALUOut), .InstrCount(InstrCount),
        .StateErr(StateErr)
    );

    // Second instance whose counter resets to all-ones, for the wrap check.
    mc_fetch_unit #(.COUNT_RESET(32'hFFFF_FFFF)) u_wrap (
        .clk(clk), .rst(rst), .NS(NS), .PCWr(PCWr), .PCWrCond(PCWrCond),
        .PCSrc(PCSrc), .IorD(IorD), .IRWr(IRWr), .Zero(Zero),
        .ALU_Result(ALU_Result), .Mem_Data(Mem_Data),
        .S(w2_s), .OP_Code(w2_op), .Funct(w2_funct), .PC(w2_pc), .Mem_Addr(w2_addr),
        .IR(w2_ir), .MDR(w2_mdr), .ALUOut(w2_alu), .InstrCount(w2_cnt),
        .StateErr(w2_err)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_ir, m_mdr, m_alu, m_cnt;
    logic [3:0]  m_s;
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ir = 32'h0; m_mdr = 32'h0; m_alu = 32'h0;
        m_cnt = 32'h0; m_s = 4'h0; m_err = 1'b0;
    endtask

    // Advance the model by one clock using the current inputs, then let the
    // DUT take the same edge and settle.
    task automatic tick();
        logic [31:0] target;
        if (PCSrc == 2'd0)      target = ALU_Result;
        else if (PCSrc == 2'd1) target = m_alu;
        else if (PCSrc == 2'd2) target = (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 4);
        else                    target = m_pc;
        if (PCWr || (PCWrCond && Zero)) m_pc = target;
        if (IRWr) begin
            m_ir  = Mem_Data;
            m_cnt = m_cnt + 1;
        end
        m_mdr = Mem_Data;
        m_alu = ALU_Result;
        if (NS > 4'd9) m_err = 1'b1;
        m_s = NS;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".S"},        {28'h0, S},        {28'h0, m_s});
        chk({tag, ".PC"},       PC,                m_pc);
        chk({tag, ".IR"},       IR,                m_ir);
        chk({tag, ".MDR"},      MDR,               m_mdr);
        chk({tag, ".ALUOut"},   ALUOut,            m_alu);
        chk({tag, ".Count"},    InstrCount,        m_cnt);
        chk({tag, ".StateErr"}, {31'h0, StateErr}, {31'h0, m_err});
        chk({tag, ".MemAddr"},  Mem_Addr,          IorD ? m_alu : m_pc);
        chk({tag, ".OpFunct"},  {20'h0, OP_Code, Funct}, {20'h0, m_ir[31:26], m_ir[5:0]});
    endtask

    task automatic idle_inputs();
        NS = 4'd0; PCWr = 1'b0; PCWrCond = 1'b0; PCSrc = 2'd0; IorD = 1'b0;
        IRWr = 1'b0; Zero = 1'b0; ALU_Result = 32'h0; Mem_Data = 32'h0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]  ns;
        logic        pcwr, cond;
        logic [1:0]  src;
        logic        iord, irwr, zero;
        logic [31:0] alu, mem;
        logic [31:0] e_pc, e_ir, e_addr;
        logic [3:0]  e_s;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [31:0] ir_v;
        // fetch
        tbl[0] = '{4'd1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h4,         32'h8C22_0004, 32'h4,         32'h8C22_0004, 32'h4,         4'd1, 32'd1};
        // load ALUOut with branch target
        tbl[1] = '{4'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h40,        32'h0,         32'h4,         32'h8C22_0004, 32'h4,         4'd2, 32'd1};
        // branch not taken
        tbl[2] = '{4'd3, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 32'h40,        32'h0,         32'h4,         32'h8C22_0004, 32'h40,        4'd3, 32'd1};
        // branch taken
        tbl[3] = '{4'd0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 32'h40,        32'h0,         32'h40,        32'h8C22_0004, 32'h40,        4'd0, 32'd1};
        // PCSrc=11 holds even when enabled
        tbl[4] = '{4'd1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 32'h999,       32'h0,         32'h40,        32'h8C22_0004, 32'h999,       4'd1, 32'd1};
        // both enables, Zero=0 still writes
        tbl[5] = '{4'd2, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'hA000_0010, 32'h0,         32'hA000_0010, 32'h8C22_0004, 32'hA000_0010, 4'd2, 32'd1};
        // load jump instruction
        tbl[6] = '{4'd3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0800_0100, 32'hA000_0010, 32'h0800_0100, 32'hA000_0010, 4'd3, 32'd2};
        // jump, NS at the legal maximum
        tbl[7] = '{4'd9, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 32'h8,         32'h0,         32'hA000_0400, 32'h0800_0100, 32'h8,         4'd9, 32'd2};
        // PC <- ALUOut (8)
        tbl[8] = '{4'd4, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 32'h100,       32'h0,         32'h8,         32'h0800_0100, 32'h100,       4'd4, 32'd2};
        tbl[9] = '{4'd5, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h100,       32'h0,         32'h8,         32'h0800_0100, 32'h8,         4'd5, 32'd2};

        // ---------------- reset state ----------------
        idle_inputs();
        rst = 1'b1;
        model_reset();
        #1;
        chk("reset.PC",      PC, 32'h0);
        chk("reset.S",       {28'h0, S}, 32'h0);
        chk("reset.IR",      IR, 32'h0);
        chk("reset.MDR",     MDR, 32'h0);
        chk("reset.ALUOut",  ALUOut, 32'h0);
        chk("reset.Count",   InstrCount, 32'h0);
        chk("reset.Err",     {31'h0, StateErr}, 32'h0);
        chk("reset.MemAddr", Mem_Addr, 32'h0);
        #11;
        rst = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < 10; i++) begin
            NS = tbl[i].ns; PCWr = tbl[i].pcwr; PCWrCond = tbl[i].cond;
            PCSrc = tbl[i].src; IorD = tbl[i].iord; IRWr = tbl[i].irwr;
            Zero = tbl[i].zero; ALU_Result = tbl[i].alu; Mem_Data = tbl[i].mem;
            tick();
            ir_v = tbl[i].e_ir;
            chk($sformatf("vec%0d.PC", i),      PC, tbl[i].e_pc);
            chk($sformatf("vec%0d.IR", i),      IR, tbl[i].e_ir);
            chk($sformatf("vec%0d.MemAddr", i), Mem_Addr, tbl[i].e_addr);
            chk($sformatf("vec%0d.S", i),       {28'h0, S}, {28'h0, tbl[i].e_s});
            chk($sformatf("vec%0d.Count", i),   InstrCount, tbl[i].e_cnt);
            chk($sformatf("vec%0d.OpCode", i),  {26'h0, OP_Code}, {26'h0, ir_v[31:26]});
            chk($sformatf("vec%0d.Err", i),     {31'h0, StateErr}, 32'h0);
        end

        // ---------------- address mux is combinational ----------------
        IorD = 1'b1; #1;
        chk("mux.IorD1", Mem_Addr, 32'h100);
        IorD = 1'b0; #1;
        chk("mux.IorD0", Mem_Addr, 32'h8);

        // ---------------- illegal state ----------------
        idle_inputs();
        NS = 4'hC;
        tick();
        chk("serr.S_C",  {28'h0, S}, 32'hC);
        chk("serr.set",  {31'h0, StateErr}, 32'h1);
        chk("serr.PC",   PC, 32'h8);
        NS = 4'h0;
        tick();
        chk("serr.S_0",  {28'h0, S}, 32'h0);
        tick();
        tick();
        chk("serr.sticky", {31'h0, StateErr}, 32'h1);

        // ---------------- asynchronous reset mid-cycle ----------------
        NS = 4'd3; PCWr = 1'b1; PCSrc = 2'd0; ALU_Result = 32'h1234;
        IRWr = 1'b1; Mem_Data = 32'hDEAD_BEEF;
        tick();
        chk("pre_rst.PC", PC, 32'h1234);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst.PC",      PC, 32'h0);
        chk("arst.S",       {28'h0, S}, 32'h0);
        chk("arst.IR",      IR, 32'h0);
        chk("arst.Count",   InstrCount, 32'h0);
        chk("arst.Err",     {31'h0, StateErr}, 32'h0);
        chk("arst.MemAddr", Mem_Addr, 32'h0);
        chk("arst.WrapCnt", w2_cnt, 32'hFFFF_FFFF);
        #1;
        rst = 1'b0;
        NS = 4'd6; PCWr = 1'b0; IRWr = 1'b1; Mem_Data = 32'h0000_002A;
        tick();
        chk("post_rst.S",  {28'h0, S}, 32'h6);
        chk("wrap.Count",  w2_cnt, 32'h0);
        chk("post_rst.Funct", {26'h0, Funct}, 32'h2A);
        chk_all("post_rst");

        // ---------------- randomized against model ----------------
        for (int i = 0; i < 600; i++) begin
            NS = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15))
                                              : 4'($urandom_range(0, 9));
            PCWr       = 1'($urandom_range(0, 1));
            PCWrCond   = 1'($urandom_range(0, 1));
            PCSrc      = 2'($urandom_range(0, 3));
            IorD       = 1'($urandom_range(0, 1));
            IRWr       = 1'($urandom_range(0, 1));
            Zero       = 1'($urandom_range(0, 1));
            ALU_Result = $urandom;
            Mem_Data   = $urandom;
            if (i % 80 == 79) begin
                #2;
                rst = 1'b1;
                #1;
                model_reset();
                chk_all("rnd_rst");
                #1;
                rst = 1'b0;
            end
            tick();
            chk_all("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_fetch_unit.md
MC_FETCH_UNIT -- requirements
Module: mc_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: MAX_STATE, default 4'd9, highest legal control-state encoding.
REQ-003 clk  input  1  single clock; all registers update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 NS  input  4  next control state from the multi-cycle control unit.
REQ-006 PCWr  input  1  unconditional PC write enable.
REQ-007 PCWrCond  input  1  branch PC write enable, qualified by Zero.
REQ-008 PCSrc  input  2  next-PC select.
REQ-009 IorD  input  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 IRWr  input  1  instruction register load enable.
REQ-011 Zero  input  1  ALU zero flag, valid in the same cycle.
REQ-012 ALU_Result  input  32  combinational ALU output.
REQ-013 Mem_Data  input  32  memory read data, valid in the same cycle.
REQ-014 S  output  4  current control state, fed back to the control unit.
REQ-015 OP_Code  output  6  IR[31:26], fed to the control unit.
REQ-016 Funct  output  6  IR[5:0].
REQ-017 PC  output  32  program counter register.
REQ-018 Mem_Addr  output  32  memory address.
REQ-019 IR, MDR, ALUOut  output  32 each  instruction, memory-data and ALU-result registers.
REQ-020 InstrCount  output  32  count of instruction fetches.
REQ-021 StateErr  output  1  sticky flag for an illegal state.

Function
REQ-022 S SHALL load NS on every clock edge, with no enable.
REQ-023 PC SHALL update only when PCWr | (PCWrCond & Zero) is 1.
REQ-024 PC next value SHALL be selected by PCSrc:
- 00 = ALU_Result.
- 01 = ALUOut.
- 10 = {PC[31:28], IR[25:0], 2'b00}.
- 11 = current PC (hold, even when enabled).
REQ-025 IR SHALL load Mem_Data when IRWr = 1, and otherwise hold.
REQ-026 MDR SHALL load Mem_Data on every edge.
REQ-027 ALUOut SHALL load ALU_Result on every edge.
REQ-028 Mem_Addr SHALL be combinational: IorD ? ALUOut : PC, with zero latency.
REQ-029 OP_Code and Funct SHALL be combinational slices of IR, changing the cycle after the IRWr edge.
REQ-030 InstrCount SHALL increment by 1 on each edge where IRWr = 1, and wrap from 32'hFFFF_FFFF to 0.
REQ-031 StateErr SHALL set on an edge where NS > MAX_STATE, and stay set until reset.
REQ-032 An illegal NS SHALL still be loaded into S; the block SHALL perform no other correction.
REQ-033 When PCWr and PCWrCond are both 1, PC SHALL update regardless of Zero.
REQ-034 IRWr together with a PC write in the same cycle SHALL update both registers.
- IR receives Mem_Data addressed by the old PC.
REQ-035 All arithmetic SHALL be 32-bit unsigned, with no overflow detection.

Reset
REQ-036 While rst = 1, register values SHALL be: PC = RESET_PC; S = 0; IR = MDR = ALUOut = 0; InstrCount = 0; StateErr = 0.
- Reset takes effect immediately, without waiting for a clock edge.
REQ-037 Reset asserted mid-instruction SHALL abandon that instruction.
- The first edge after deassertion loads S from NS.
REQ-038 While rst = 1, Mem_Addr SHALL equal RESET_PC when IorD = 0.

Verification
REQ-039 Fetch: reset, then PCWr=1, IRWr=1, PCSrc=00, ALU_Result=4, Mem_Data=32'h8C22_0004 -> next cycle PC=4, IR=32'h8C22_0004, OP_Code=6'h23, InstrCount=1.
REQ-040 Branch: PCWrCond=1, PCWr=0, PCSrc=01, ALUOut=32'h40.
- Zero=0 -> PC unchanged.
- Zero=1 -> PC=32'h40.
REQ-041 Jump: PC=32'hA000_0010, IR=32'h0800_0100, PCWr=1, PCSrc=10 -> PC=32'hA000_0400.
REQ-042 Address mux: ALUOut=32'h100, PC=8.
- IorD=1 -> Mem_Addr=32'h100 in the same cycle.
- IorD=0 -> Mem_Addr=8.
REQ-043 State error: NS=4'hC for one cycle, then NS=0 -> S=C then 0; StateErr=1 and stays 1 until rst pulse.
REQ-044 Async reset mid-cycle: assert rst between edges -> PC=RESET_PC and S=0 before the next edge; InstrCount preset to 32'hFFFF_FFFF then IRWr -> wraps to 0.
